// File: rtl/digits_to_time_if.sv
// Entry-side bundle for digits_to_time: digit/control strobes in, committed time and status out.
interface digits_to_time_if;
    logic       clear;
    logic       digit_valid;
    logic [3:0] digit;
    logic       back;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       time_valid;
    logic       digit_err;
    logic [1:0] pos;
    logic       entry_active;

    modport master (
        output clear, digit_valid, digit, back,
        input  minutes, seconds, time_valid, digit_err, pos, entry_active
    );

    modport slave (
        input  clear, digit_valid, digit, back,
        output minutes, seconds, time_valid, digit_err, pos, entry_active
    );
endinterface

// File: rtl/digits_to_time.sv
// Sequential BCD MM:SS entry: stages range-checked digits, commits binary minutes/seconds.
// Optional backspace support enabled by defining DIGITS_TO_TIME_BACKSPACE_EN.
module digits_to_time #(
    parameter int unsigned MAX_MIN_TENS = 5,
    parameter int unsigned MAX_SEC_TENS = 5
) (
    input logic          clk,
    input logic          rst_n,
    digits_to_time_if.slave bus
);

    typedef enum logic [1:0] {
        S_M1 = 2'd0,
        S_M0 = 2'd1,
        S_S1 = 2'd2,
        S_S0 = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] m1_q, m1_d, s1_q, s1_d;
    logic [5:0] stg_min_q, stg_min_d;
    logic [5:0] min_q, min_d, sec_q, sec_d;
    logic       tv_q, tv_d, err_q, err_d, act_q;
    logic [3:0] limit;
    logic       ok;

    // tens*10 + ones via shifts; tens never exceeds 5 so the sum fits in 6 bits
    function automatic logic [5:0] bcd2bin(input logic [3:0] t, input logic [3:0] o);
        return (6'(t) << 3) + (6'(t) << 1) + 6'(o);
    endfunction

    always_comb begin
        state_d   = state_q;
        m1_d      = m1_q;
        s1_d      = s1_q;
        stg_min_d = stg_min_q;
        min_d     = min_q;
        sec_d     = sec_q;
        tv_d      = 1'b0;
        err_d     = 1'b0;
        limit     = 4'd9;

        case (state_q)
            S_M1:    limit = 4'(MAX_MIN_TENS);
            S_S1:    limit = 4'(MAX_SEC_TENS);
            default: limit = 4'd9;
        endcase
        ok = (bus.digit <= limit);

        if (bus.clear) begin
            state_d   = S_M1;
            m1_d      = '0;
            s1_d      = '0;
            stg_min_d = '0;
        end else if (bus.digit_valid) begin
            if (!ok) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    S_M1: begin
                        m1_d    = bus.digit;
                        state_d = S_M0;
                    end
                    S_M0: begin
                        stg_min_d = bcd2bin(m1_q, bus.digit);
                        state_d   = S_S1;
                    end
                    S_S1: begin
                        s1_d    = bus.digit;
                        state_d = S_S0;
                    end
                    default: begin
                        min_d     = stg_min_q;
                        sec_d     = bcd2bin(s1_q, bus.digit);
                        tv_d      = 1'b1;
                        state_d   = S_M1;
                        m1_d      = '0;
                        s1_d      = '0;
                        stg_min_d = '0;
                    end
                endcase
            end
        end
`ifdef DIGITS_TO_TIME_BACKSPACE_EN
        else if (bus.back) begin
            // step back one position and forget the digit stored there
            case (state_q)
                S_M0: begin
                    state_d = S_M1;
                    m1_d    = '0;
                end
                S_S1: begin
                    state_d   = S_M0;
                    stg_min_d = bcd2bin(m1_q, 4'd0);
                end
                S_S0: begin
                    state_d = S_S1;
                    s1_d    = '0;
                end
                default: state_d = state_q;
            endcase
        end
`endif
    end

`ifndef DIGITS_TO_TIME_BACKSPACE_EN
    logic unused_back;
    assign unused_back = bus.back;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_M1;
            m1_q      <= '0;
            s1_q      <= '0;
            stg_min_q <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            tv_q      <= 1'b0;
            err_q     <= 1'b0;
            act_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m1_q      <= m1_d;
            s1_q      <= s1_d;
            stg_min_q <= stg_min_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            tv_q      <= tv_d;
            err_q     <= err_d;
            act_q     <= (state_d != S_M1);
        end
    end

    assign bus.minutes      = min_q;
    assign bus.seconds      = sec_q;
    assign bus.time_valid   = tv_q;
    assign bus.digit_err    = err_q;
    assign bus.pos          = state_q;
    assign bus.entry_active = act_q;

endmodule
